alzette_seq: RTL

Multi-cycle sequencer that evaluates one complete Alzette ARX-box (4 rounds, encrypt or decrypt) on a 64-bit state (x, y) with a 32-bit round constant c. It time-multiplexes a single add/sub + xor + rotate step datapath over 8 cycles. It sits beside the Alzette coprocessor ISE as a multi-cycle accelerator path, and is fed and drained through valid/ready handshakes.

---
 rtl/alzette_pkg.sv | 19 +
 rtl/alzette_seq_if.sv | 27 ++
 rtl/alzette_seq_step.sv | 43 ++++
 rtl/alzette_seq.sv | 87 ++++++++
 4 files changed

// File: rtl/alzette_pkg.sv
// Shared types, rotation tables and rotate helper for the Alzette
// multi-cycle sequencer.
package alzette_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Rotation amounts per round, in encrypt order
   localparam logic [4:0] ROT_R [0:3] = '{5'd31, 5'd17, 5'd0,  5'd24};
   localparam logic [4:0] ROT_S [0:3] = '{5'd24, 5'd17, 5'd31, 5'd16};

   function automatic word_t ror32(input word_t v, input logic [4:0] n);
      logic [63:0] w;
      w = {v, v} >> n;
      return w[31:0];
   endfunction

endpackage

// File: rtl/alzette_seq_if.sv
// Request/response handshake bundle between an Alzette client and the
// sequencer.
interface alzette_seq_if;
   import alzette_pkg::*;

   logic  req_valid;
   logic  req_ready;
   logic  req_dec;
   word_t req_x;
   word_t req_y;
   word_t req_c;
   logic  rsp_valid;
   logic  rsp_ready;
   word_t rsp_x;
   word_t rsp_y;

   modport master (
      output req_valid, req_dec, req_x, req_y, req_c, rsp_ready,
      input  req_ready, rsp_valid, rsp_x, rsp_y
   );

   modport slave (
      input  req_valid, req_dec, req_x, req_y, req_c, rsp_ready,
      output req_ready, rsp_valid, rsp_x, rsp_y
   );

endinterface

// File: rtl/alzette_seq_step.sv
// One Alzette half-round (phase A or B) for encrypt or decrypt; purely
// combinational.
module alzette_step
   import alzette_pkg::*;
#(
   parameter bit DEC_EN = 1'b1
) (
   input  word_t      i_x,
   input  word_t      i_y,
   input  word_t      i_c,
   input  logic [4:0] i_r,
   input  logic [4:0] i_s,
   input  logic       i_dec,
   input  logic       i_phase,
   output word_t      o_x_nxt,
   output word_t      o_y_nxt
);

   word_t w_x1;
   assign w_x1 = i_x ^ i_c;

   // With DEC_EN=0 the decrypt branch is constant-false and the subtractor drops out
   always_comb begin
      o_x_nxt = i_x;
      o_y_nxt = i_y;
      if (DEC_EN && i_dec) begin
         if (!i_phase) begin
            o_y_nxt = i_y ^ ror32(w_x1, i_s);
            o_x_nxt = w_x1;
         end else begin
            o_x_nxt = i_x - ror32(i_y, i_r);
         end
      end else begin
         if (!i_phase) begin
            o_x_nxt = i_x + ror32(i_y, i_r);
         end else begin
            o_y_nxt = i_y ^ ror32(i_x, i_s);
            o_x_nxt = w_x1;
         end
      end
   end

endmodule

// File: rtl/alzette_seq.sv
// Eight-cycle Alzette ARX-box sequencer: one shared step datapath driven
// by a 3-bit step counter, fed and drained through valid/ready.
module alzette_seq
   import alzette_pkg::*;
#(
   parameter bit DEC_EN = 1'b1
) (
   input  logic         cop_clk,
   input  logic         cop_rst,
   alzette_seq_if.slave bus,
   output logic         busy
);

   state_t     r_state;
   logic [2:0] r_step;
   word_t      r_x, r_y, r_c;
   logic       r_dec;
   logic       r_req_ready, r_rsp_valid, r_busy;

   logic [1:0] w_rnd;
   word_t      w_x_nxt, w_y_nxt;

   // Decrypt walks the rounds backwards
   assign w_rnd = r_dec ? (2'd3 - r_step[2:1]) : r_step[2:1];

   alzette_step #(.DEC_EN(DEC_EN)) u_step (
      .i_x     (r_x),
      .i_y     (r_y),
      .i_c     (r_c),
      .i_r     (ROT_R[w_rnd]),
      .i_s     (ROT_S[w_rnd]),
      .i_dec   (r_dec),
      .i_phase (r_step[0]),
      .o_x_nxt (w_x_nxt),
      .o_y_nxt (w_y_nxt)
   );

   always_ff @(posedge cop_clk) begin
      if (!cop_rst) begin
         r_state     <= IDLE;
         r_step      <= 3'd0;
         r_x         <= '0;
         r_y         <= '0;
         r_c         <= '0;
         r_dec       <= 1'b0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (bus.req_valid) begin
               r_x         <= bus.req_x;
               r_y         <= bus.req_y;
               r_c         <= bus.req_c;
               r_dec       <= DEC_EN ? bus.req_dec : 1'b0;
               r_step      <= 3'd0;
               r_state     <= RUN;
               r_req_ready <= 1'b0;
               r_busy      <= 1'b1;
            end
            RUN: begin
               r_x    <= w_x_nxt;
               r_y    <= w_y_nxt;
               r_step <= r_step + 3'd1;
               if (r_step == 3'd7) begin
                  r_state     <= DONE;
                  r_busy      <= 1'b0;
                  r_rsp_valid <= 1'b1;
               end
            end
            DONE: if (bus.rsp_ready) begin
               r_state     <= IDLE;
               r_rsp_valid <= 1'b0;
               r_req_ready <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = r_req_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_x     = r_x;
   assign bus.rsp_y     = r_y;
   assign busy          = r_busy;

endmodule
